// File: rtl/pipe_pkg.sv
// Shared ID/EXE types: decode bundle layout, command/branch encodings and skid-buffer states.
package pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CMD_W  = 4;
  localparam int unsigned BR_W   = 2;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [BR_W-1:0] {
    BR_NONE = 2'd0,
    BR_BEZ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_type_e;

  typedef enum logic [CMD_W-1:0] {
    EXE_NOP = 4'd0,
    EXE_MOV = 4'd1,
    EXE_MVN = 4'd9,
    EXE_ADD = 4'd2,
    EXE_ADC = 4'd3,
    EXE_SUB = 4'd4,
    EXE_SBC = 4'd5,
    EXE_AND = 4'd6,
    EXE_ORR = 4'd7,
    EXE_EOR = 4'd8
  } exe_cmd_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] reg2;
    logic [REG_W-1:0]  dest;
    logic [BR_W-1:0]   br_type;
    logic [CMD_W-1:0]  exe_cmd;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
  } id_exe_bundle_t;

  localparam int unsigned BUNDLE_W = $bits(id_exe_bundle_t);

endpackage

// File: rtl/id_exe_pipe_reg_if.sv
// Decode-to-EXE handshake bundle; slave is the pipe register, master is the surrounding pipeline.
interface id_exe_pipe_reg_if;
  import pipe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_val1;
  logic [DATA_W-1:0] in_val2;
  logic [DATA_W-1:0] in_reg2;
  logic [REG_W-1:0]  in_dest;
  logic [BR_W-1:0]   in_br_type;
  logic [CMD_W-1:0]  in_exe_cmd;
  logic              in_mem_r_en;
  logic              in_mem_w_en;
  logic              in_wb_en;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_val1;
  logic [DATA_W-1:0] out_val2;
  logic [DATA_W-1:0] out_reg2;
  logic [REG_W-1:0]  out_dest;
  logic [BR_W-1:0]   out_br_type;
  logic [CMD_W-1:0]  out_exe_cmd;
  logic              out_mem_r_en;
  logic              out_mem_w_en;
  logic              out_wb_en;

  modport slave (
    input  in_valid, in_val1, in_val2, in_reg2, in_dest, in_br_type, in_exe_cmd,
           in_mem_r_en, in_mem_w_en, in_wb_en, out_ready,
    output in_ready, out_valid, out_val1, out_val2, out_reg2, out_dest, out_br_type,
           out_exe_cmd, out_mem_r_en, out_mem_w_en, out_wb_en
  );

  modport master (
    output in_valid, in_val1, in_val2, in_reg2, in_dest, in_br_type, in_exe_cmd,
           in_mem_r_en, in_mem_w_en, in_wb_en, out_ready,
    input  in_ready, out_valid, out_val1, out_val2, out_reg2, out_dest, out_br_type,
           out_exe_cmd, out_mem_r_en, out_mem_w_en, out_wb_en
  );

endinterface

// File: rtl/id_exe_pipe_reg_skid.sv
// Two-entry skid buffer (head + skid) with registered ready and synchronous flush.
module skid_buffer2
  import pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] head_q, skid_q;
  logic         head_ld, skid_ld, head_from_skid;
  logic         push, pop;

  // Handshake flags decode the state register only, so ready never sees out_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    skid_ld        = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_ld = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_ld = 1'b1;
          end else if (push) begin
            state_d = TWO;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d        = ONE;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Payload flops; stale data after flush is harmless because validity lives in state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_ld)             head_q <= in_data;
      else if (head_from_skid) head_q <= skid_q;
      if (skid_ld)             skid_q <= in_data;
    end
  end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register: packs the decode bundle into a 2-entry skid buffer and emits bubbles when empty.
// Optional stall/flush counters are built when PIPE_STATS_EN is defined.
module id_exe_pipe_reg
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  id_exe_pipe_reg_if.slave  bus
`ifdef PIPE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall_cnt,
  output logic [STAT_W-1:0] stat_flush_cnt
`endif
);

  id_exe_bundle_t in_bundle, head;
  logic [BUNDLE_W-1:0] head_data;

  always_comb begin
    in_bundle          = '0;
    in_bundle.val1     = bus.in_val1;
    in_bundle.val2     = bus.in_val2;
    in_bundle.reg2     = bus.in_reg2;
    in_bundle.dest     = bus.in_dest;
    in_bundle.br_type  = bus.in_br_type;
    in_bundle.exe_cmd  = bus.in_exe_cmd;
    in_bundle.mem_r_en = bus.in_mem_r_en;
    in_bundle.mem_w_en = bus.in_mem_w_en;
    in_bundle.wb_en    = bus.in_wb_en;
  end

  skid_buffer2 #(.W(BUNDLE_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_bundle),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head_data)
  );

  assign head = id_exe_bundle_t'(head_data);

  // Side-effect controls are masked so an empty slot reaches EXE as a bubble.
  assign bus.out_val1     = head.val1;
  assign bus.out_val2     = head.val2;
  assign bus.out_reg2     = head.reg2;
  assign bus.out_dest     = head.dest;
  assign bus.out_exe_cmd  = head.exe_cmd;
  assign bus.out_br_type  = bus.out_valid ? head.br_type : '0;
  assign bus.out_mem_r_en = bus.out_valid & head.mem_r_en;
  assign bus.out_mem_w_en = bus.out_valid & head.mem_w_en;
  assign bus.out_wb_en    = bus.out_valid & head.wb_en;

`ifdef PIPE_STATS_EN
  logic discard_c;

  // A flush discards something if a bundle stays held after any pop, or a push is squashed.
  assign discard_c = ~bus.in_ready
                   | (bus.out_valid & ~bus.out_ready)
                   | (bus.in_valid & bus.in_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall_cnt <= '0;
      stat_flush_cnt <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && (stat_stall_cnt != '1))
        stat_stall_cnt <= stat_stall_cnt + STAT_W'(1);
      if (flush && discard_c && (stat_flush_cnt != '1))
        stat_flush_cnt <= stat_flush_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Self-checking bench for id_exe_pipe_reg against a queue-based FIFO reference model.
module tb_id_exe_pipe_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  id_exe_pipe_reg_if bus ();

`ifdef PIPE_STATS_EN
  logic [STAT_W-1:0] stat_stall_cnt, stat_flush_cnt;
  logic [STAT_W-1:0] exp_stall = '0, exp_flush = '0;
`endif

  id_exe_pipe_reg dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef PIPE_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_flush_cnt (stat_flush_cnt)
`endif
  );

  int checks = 0;
  int passed = 0;
  id_exe_bundle_t mq[$];

  function automatic id_exe_bundle_t mk(input logic [REG_W-1:0] d, input logic [DATA_W-1:0] v1,
                                        input logic wb);
    id_exe_bundle_t b;
    b = '0;
    b.dest = d;
    b.val1 = v1;
    b.wb_en = wb;
    b.mem_r_en = d[0];
    b.br_type = d[1:0];
    return b;
  endfunction

  function automatic id_exe_bundle_t rand_b();
    id_exe_bundle_t b;
    b.val1     = $urandom;
    b.val2     = $urandom;
    b.reg2     = $urandom;
    b.dest     = REG_W'($urandom);
    b.br_type  = BR_W'($urandom);
    b.exe_cmd  = CMD_W'($urandom);
    b.mem_r_en = 1'($urandom);
    b.mem_w_en = 1'($urandom);
    b.wb_en    = 1'($urandom);
    return b;
  endfunction

  function automatic id_exe_bundle_t observe();
    id_exe_bundle_t b;
    b.val1     = bus.out_val1;
    b.val2     = bus.out_val2;
    b.reg2     = bus.out_reg2;
    b.dest     = bus.out_dest;
    b.br_type  = bus.out_br_type;
    b.exe_cmd  = bus.out_exe_cmd;
    b.mem_r_en = bus.out_mem_r_en;
    b.mem_w_en = bus.out_mem_w_en;
    b.wb_en    = bus.out_wb_en;
    return b;
  endfunction

  task automatic drive(input logic v, input id_exe_bundle_t b, input logic ordy, input logic fl);
    bus.in_valid    = v;
    bus.in_val1     = b.val1;
    bus.in_val2     = b.val2;
    bus.in_reg2     = b.reg2;
    bus.in_dest     = b.dest;
    bus.in_br_type  = b.br_type;
    bus.in_exe_cmd  = b.exe_cmd;
    bus.in_mem_r_en = b.mem_r_en;
    bus.in_mem_w_en = b.mem_w_en;
    bus.in_wb_en    = b.wb_en;
    bus.out_ready   = ordy;
    flush           = fl;
  endtask

  // Advance one clock and update the reference FIFO (capacity 2) from the inputs seen at that edge.
  task automatic step();
    id_exe_bundle_t inb;
    bit pop, push;
    inb  = '{bus.in_val1, bus.in_val2, bus.in_reg2, bus.in_dest, bus.in_br_type,
             bus.in_exe_cmd, bus.in_mem_r_en, bus.in_mem_w_en, bus.in_wb_en};
    pop  = (mq.size() > 0) && bus.out_ready;
    push = bus.in_valid && (mq.size() < 2);
`ifdef PIPE_STATS_EN
    begin
      int held;
      held = mq.size() - int'(pop);
      if (mq.size() > 0 && !bus.out_ready && exp_stall != '1) exp_stall = exp_stall + STAT_W'(1);
      if (flush && (held > 0 || push) && exp_flush != '1) exp_flush = exp_flush + STAT_W'(1);
    end
`endif
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(inb);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_wb_en !== 1'b0 ||
        bus.out_val1 !== '0 || bus.out_dest !== '0)
      $display("FAIL reset_state: valid=%b ready=%b wb=%b val1=%h dest=%0d, want 0 1 0 0 0",
               bus.out_valid, bus.in_ready, bus.out_wb_en, bus.out_val1, bus.out_dest);
    else passed++;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_pass_through();
    drive(1'b1, mk(5'd3, 32'h0000_0005, 1'b1), 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_val1 !== 32'd5 || bus.out_dest !== 5'd3 || bus.out_wb_en !== 1'b1)
      $display("FAIL pass_through: valid=%b val1=%h dest=%0d wb=%b, want 1 5 3 1",
               bus.out_valid, bus.out_val1, bus.out_dest, bus.out_wb_en);
    else passed++;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_wb_en !== 1'b0 || bus.out_mem_r_en !== 1'b0 || bus.out_br_type !== '0)
      $display("FAIL pass_drain: valid=%b wb=%b rd=%b br=%0d, want all 0",
               bus.out_valid, bus.out_wb_en, bus.out_mem_r_en, bus.out_br_type);
    else passed++;
  endtask

  task automatic test_back_pressure();
    drive(1'b1, mk(5'd1, 32'hA, 1'b1), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(5'd2, 32'hB, 1'b1), 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_dest !== 5'd1)
      $display("FAIL bp_full: in_ready=%b dest=%0d, want 0 1", bus.in_ready, bus.out_dest);
    else passed++;
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_dest !== 5'd1 || bus.out_val1 !== 32'hA)
      $display("FAIL bp_first: valid=%b dest=%0d val1=%h, want 1 1 a", bus.out_valid, bus.out_dest, bus.out_val1);
    else passed++;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_dest !== 5'd2 || bus.out_val1 !== 32'hB || bus.in_ready !== 1'b1)
      $display("FAIL bp_second: valid=%b dest=%0d val1=%h rdy=%b, want 1 2 b 1",
               bus.out_valid, bus.out_dest, bus.out_val1, bus.in_ready);
    else passed++;
    step();
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL bp_empty: valid=%b, want 0", bus.out_valid);
    else passed++;
  endtask

  task automatic test_flush();
    drive(1'b1, mk(5'd4, 32'h4, 1'b1), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(5'd5, 32'h5, 1'b1), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(5'd7, 32'h7, 1'b1), 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_wb_en !== 1'b0 ||
        bus.out_mem_r_en !== 1'b0 || bus.out_mem_w_en !== 1'b0 || bus.out_br_type !== '0)
      $display("FAIL flush_bubble: valid=%b rdy=%b wb=%b rd=%b wr=%b br=%0d, want 0 1 0 0 0 0",
               bus.out_valid, bus.in_ready, bus.out_wb_en, bus.out_mem_r_en, bus.out_mem_w_en, bus.out_br_type);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0)
        $display("FAIL flush_no_emit: valid=%b dest=%0d, want valid 0", bus.out_valid, bus.out_dest);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, mk(5'd1, 32'd1, 1'b1), 1'b1, 1'b0);
    step();
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_dest !== 5'(k) || bus.in_ready !== 1'b1)
        $display("FAIL b2b_%0d: valid=%b dest=%0d rdy=%b, want 1 %0d 1",
                 k, bus.out_valid, bus.out_dest, bus.in_ready, k);
      else passed++;
      if (k < 10) drive(1'b1, mk(5'(k + 1), 32'(k + 1), 1'b1), 1'b1, 1'b0);
      else        drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL b2b_drain: valid=%b, want 0", bus.out_valid);
    else passed++;
  endtask

  task automatic test_random();
    id_exe_bundle_t obs;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_b(), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
      step();
      obs = observe();
      checks++;
      if (bus.out_valid !== 1'(mq.size() > 0) || bus.in_ready !== 1'(mq.size() < 2))
        $display("FAIL rand_flags c%0d: valid=%b rdy=%b, want %b %b",
                 c, bus.out_valid, bus.in_ready, mq.size() > 0, mq.size() < 2);
      else passed++;
      checks++;
      if (mq.size() > 0) begin
        if (obs !== mq[0]) $display("FAIL rand_data c%0d: got %h want %h", c, obs, mq[0]);
        else passed++;
      end else begin
        if ({obs.mem_r_en, obs.mem_w_en, obs.wb_en, obs.br_type} !== 5'b0)
          $display("FAIL rand_bubble c%0d: rd=%b wr=%b wb=%b br=%0d, want 0",
                   c, obs.mem_r_en, obs.mem_w_en, obs.wb_en, obs.br_type);
        else passed++;
      end
`ifdef PIPE_STATS_EN
      checks++;
      if (stat_stall_cnt !== exp_stall || stat_flush_cnt !== exp_flush)
        $display("FAIL rand_stats c%0d: stall=%0d flush=%0d want %0d %0d",
                 c, stat_stall_cnt, stat_flush_cnt, exp_stall, exp_flush);
      else passed++;
`endif
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, mk(5'd9, 32'h9, 1'b1), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(5'd10, 32'h10, 1'b1), 1'b0, 1'b0);
    step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_wb_en !== 1'b0 || bus.out_val1 !== '0)
      $display("FAIL reset_mid: valid=%b rdy=%b wb=%b val1=%h, want 0 1 0 0",
               bus.out_valid, bus.in_ready, bus.out_wb_en, bus.out_val1);
    else passed++;
`ifdef PIPE_STATS_EN
    checks++;
    if (stat_stall_cnt !== '0 || stat_flush_cnt !== '0)
      $display("FAIL reset_stats: stall=%0d flush=%0d, want 0 0", stat_stall_cnt, stat_flush_cnt);
    else passed++;
    exp_stall = '0;
    exp_flush = '0;
`endif
    mq.delete();
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk) rst = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL reset_mid_after: valid=%b, want 0", bus.out_valid);
    else passed++;
  endtask

`ifdef PIPE_STATS_EN
  task automatic test_stats();
    logic [STAT_W-1:0] s0, f0;
    s0 = stat_stall_cnt;
    f0 = stat_flush_cnt;
    drive(1'b1, mk(5'd1, 32'h1, 1'b1), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(5'd2, 32'h2, 1'b1), 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    drive(1'b0, '0, 1'b1, 1'b1);
    step();
    checks++;
    if (stat_stall_cnt !== s0 + STAT_W'(3) || stat_flush_cnt !== f0 + STAT_W'(1))
      $display("FAIL stats_flush: stall=%0d flush=%0d, want %0d %0d",
               stat_stall_cnt, stat_flush_cnt, s0 + STAT_W'(3), f0 + STAT_W'(1));
    else passed++;
    drive(1'b0, '0, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (stat_stall_cnt !== s0 + STAT_W'(3) || stat_flush_cnt !== f0 + STAT_W'(1))
      $display("FAIL stats_empty_flush: stall=%0d flush=%0d, want %0d %0d",
               stat_stall_cnt, stat_flush_cnt, s0 + STAT_W'(3), f0 + STAT_W'(1));
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_pass_through();
    test_back_pressure();
    test_flush();
    test_back_to_back();
    test_random();
`ifdef PIPE_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
